// File: rtl/pcs_tx_oset_gen.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_oset_gen
// Brief    : 1000BASE-X PCS transmit ordered-set generator. Turns GMII-style
//            TX_EN/TX_ER/TXD into an 8-bit code-group stream with a K flag,
//            ahead of the 8b/10b encoder. Tracks even/odd slots, aligns /S/
//            to even slots behind a ready handshake, enforces a minimum IPG,
//            propagates errors as /V/, supports carrier extension and pads
//            the end-of-packet delimiter so idle restarts on an even slot.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_oset_gen #(
  parameter int         IPG_MIN  = 12,
  parameter int         EXT_EN   = 1,
  parameter int         ERR_PROP = 1,
  parameter logic [7:0] IDLE_D   = 8'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic       TX_ER,
  input  logic [7:0] TXD,
  output logic       tx_ready,
  output logic [7:0] tx_o_set,
  output logic       tx_o_set_k,
  output logic       tx_even,
  output logic       transmitting,
  output logic       tx_drop
);

  // State encoding
  localparam logic [2:0] c_ST_XMIT_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_DROP        = 3'd1;
  localparam logic [2:0] c_ST_START       = 3'd2;
  localparam logic [2:0] c_ST_TX_DATA     = 3'd3;
  localparam logic [2:0] c_ST_END         = 3'd4;
  localparam logic [2:0] c_ST_CARRIER_EXT = 3'd5;
  localparam logic [2:0] c_ST_EPD2        = 3'd6;
  localparam logic [2:0] c_ST_EPD3        = 3'd7;

  // Code-group octets
  localparam logic [7:0] c_OS_K28_5 = 8'hBC;
  localparam logic [7:0] c_OS_S     = 8'hFB;
  localparam logic [7:0] c_OS_T     = 8'hFD;
  localparam logic [7:0] c_OS_R     = 8'hF7;
  localparam logic [7:0] c_OS_V     = 8'hFE;
  localparam logic [7:0] c_EXT_D    = 8'h0F;

  localparam logic [5:0] c_IPG_MIN  = 6'(IPG_MIN);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [5:0] r_ipg_cnt;
  logic       w_ipg_ok;
  logic       w_start;
  logic       w_err_prop;
  logic       w_ext_en;
  logic       w_ext_req;
  logic [7:0] w_idle_oset;
  logic       w_idle_k;
  logic [7:0] w_oset_nxt;
  logic       w_k_nxt;
  logic       w_xmit_nxt;
  logic       w_drop_nxt;

  // Feature switches resolved at elaboration
  generate
    if (ERR_PROP != 0) begin : g_err_prop_on
      assign w_err_prop = 1'b1;
    end else begin : g_err_prop_off
      assign w_err_prop = 1'b0;
    end

    if (EXT_EN != 0) begin : g_ext_on
      assign w_ext_en = 1'b1;
    end else begin : g_ext_off
      assign w_ext_en = 1'b0;
    end
  endgenerate

  // Handshake and shared decodes; the slot being produced next is even
  // exactly when the current slot is odd.
  assign w_ipg_ok    = (r_ipg_cnt >= c_IPG_MIN);
  assign tx_ready    = (r_state == c_ST_XMIT_IDLE) & ~tx_even & w_ipg_ok;
  assign w_start     = TX_EN & tx_ready;
  assign w_ext_req   = w_ext_en & TX_ER & ~TX_EN;
  assign w_idle_oset = tx_even ? IDLE_D : c_OS_K28_5;
  assign w_idle_k    = ~tx_even;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_XMIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_XMIT_IDLE: begin
        if (TX_EN) begin
          w_state_nxt = tx_ready ? c_ST_START : c_ST_DROP;
        end
      end
      c_ST_DROP: begin
        if (!TX_EN) begin
          w_state_nxt = c_ST_XMIT_IDLE;
        end
      end
      // START already treats its inputs as the first data cycle
      c_ST_START, c_ST_TX_DATA: begin
        w_state_nxt = TX_EN ? c_ST_TX_DATA : c_ST_END;
      end
      c_ST_END: begin
        w_state_nxt = w_ext_req ? c_ST_CARRIER_EXT : c_ST_EPD2;
      end
      c_ST_CARRIER_EXT: begin
        if (!TX_EN && !TX_ER) begin
          w_state_nxt = c_ST_EPD2;
        end
      end
      // An /R/ that landed in an even slot needs one more /R/ as padding
      c_ST_EPD2: begin
        w_state_nxt = tx_even ? c_ST_EPD3 : c_ST_XMIT_IDLE;
      end
      c_ST_EPD3: begin
        w_state_nxt = c_ST_XMIT_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_XMIT_IDLE;
      end
    endcase
  end

  // Output decode: code-group, K flag, carrier and drop values for the next edge
  always_comb begin
    w_oset_nxt = w_idle_oset;
    w_k_nxt    = w_idle_k;
    w_xmit_nxt = transmitting;
    w_drop_nxt = 1'b0;
    case (r_state)
      c_ST_XMIT_IDLE: begin
        w_xmit_nxt = 1'b0;
        if (w_start) begin
          w_oset_nxt = c_OS_S;
          w_k_nxt    = 1'b1;
        end else if (TX_EN) begin
          w_drop_nxt = 1'b1;
        end
      end
      c_ST_DROP: begin
        w_xmit_nxt = 1'b0;
      end
      c_ST_START, c_ST_TX_DATA: begin
        w_xmit_nxt = 1'b1;
        if (!TX_EN) begin
          w_oset_nxt = c_OS_T;
          w_k_nxt    = 1'b1;
        end else if (TX_ER && w_err_prop) begin
          w_oset_nxt = c_OS_V;
          w_k_nxt    = 1'b1;
        end else begin
          w_oset_nxt = TXD;
          w_k_nxt    = 1'b0;
        end
      end
      c_ST_END: begin
        w_oset_nxt = c_OS_R;
        w_k_nxt    = 1'b1;
        w_xmit_nxt = w_ext_req;
      end
      c_ST_CARRIER_EXT: begin
        w_k_nxt = 1'b1;
        if (TX_EN) begin
          // Burst mode is not supported: a new frame during extension is an error
          w_oset_nxt = c_OS_V;
          w_xmit_nxt = 1'b1;
        end else if (!TX_ER) begin
          w_oset_nxt = c_OS_R;
          w_xmit_nxt = 1'b0;
        end else begin
          w_oset_nxt = (TXD == c_EXT_D) ? c_OS_R : c_OS_V;
          w_xmit_nxt = 1'b1;
        end
      end
      c_ST_EPD2: begin
        w_xmit_nxt = 1'b0;
        if (tx_even) begin
          w_oset_nxt = c_OS_R;
          w_k_nxt    = 1'b1;
        end
      end
      c_ST_EPD3: begin
        w_xmit_nxt = 1'b0;
      end
      default: begin
        w_xmit_nxt = 1'b0;
      end
    endcase
  end

  // Registered code-group outputs and free-running slot parity
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_o_set     <= c_OS_K28_5;
      tx_o_set_k   <= 1'b1;
      tx_even      <= 1'b1;
      transmitting <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      tx_o_set     <= w_oset_nxt;
      tx_o_set_k   <= w_k_nxt;
      tx_even      <= ~tx_even;
      transmitting <= w_xmit_nxt;
      tx_drop      <= w_drop_nxt;
    end
  end

  // Inter-packet gap counter: counts idle code-groups, cleared by /S/
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ipg_cnt <= c_IPG_MIN;
    end else if (w_start) begin
      r_ipg_cnt <= 6'd0;
    end else if (((r_state == c_ST_XMIT_IDLE) || (r_state == c_ST_DROP)) &&
                 (r_ipg_cnt < c_IPG_MIN)) begin
      r_ipg_cnt <= r_ipg_cnt + 6'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_oset_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_tx_oset_gen
// Brief    : Self-checking bench for pcs_tx_oset_gen. Two instances share the
//            stimulus: dut_a with default parameters, dut_b with ERR_PROP=0
//            and EXT_EN=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_oset_gen;

  localparam logic [7:0] c_I = 8'hBC;
  localparam logic [7:0] c_D = 8'h50;
  localparam logic [7:0] c_S = 8'hFB;
  localparam logic [7:0] c_T = 8'hFD;
  localparam logic [7:0] c_R = 8'hF7;
  localparam logic [7:0] c_V = 8'hFE;

  logic       clock;
  logic       reset;
  logic       TX_EN;
  logic       TX_ER;
  logic [7:0] TXD;

  logic       a_rdy, a_k, a_even, a_xmit, a_drop;
  logic [7:0] a_oset;
  logic       b_rdy, b_k, b_even, b_xmit, b_drop;
  logic [7:0] b_oset;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  pcs_tx_oset_gen dut_a (
    .clock(clock), .reset(reset), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
    .tx_ready(a_rdy), .tx_o_set(a_oset), .tx_o_set_k(a_k), .tx_even(a_even),
    .transmitting(a_xmit), .tx_drop(a_drop)
  );

  pcs_tx_oset_gen #(.IPG_MIN(12), .EXT_EN(0), .ERR_PROP(0), .IDLE_D(8'h50)) dut_b (
    .clock(clock), .reset(reset), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
    .tx_ready(b_rdy), .tx_o_set(b_oset), .tx_o_set_k(b_k), .tx_even(b_even),
    .transmitting(b_xmit), .tx_drop(b_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic [7:0] oset;
    logic       k;
    logic       xmit;
    logic       drop;
    logic       rdy;
    logic [7:0] oset_b;
    logic       k_b;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic er, input logic [7:0] d,
                              input logic [7:0] oset, input logic k, input logic xmit,
                              input logic drop, input logic rdy,
                              input logic [7:0] oset_b, input logic k_b);
    vec_t v;
    v.en = en; v.er = er; v.d = d; v.oset = oset; v.k = k; v.xmit = xmit;
    v.drop = drop; v.rdy = rdy; v.oset_b = oset_b; v.k_b = k_b;
    tbl.push_back(v);
  endfunction

  // Idle rows: even edges carry K28.5, odd edges carry the idle data octet
  function automatic void add_idle(input int n, input logic ipg_done);
    for (int i = 0; i < n; i++) begin
      int e;
      e = tbl.size() + 1;
      if (e % 2 == 0) add(1'b0, 1'b0, 8'h00, c_I, 1'b1, 1'b0, 1'b0, ipg_done, c_I, 1'b1);
      else            add(1'b0, 1'b0, 8'h00, c_D, 1'b0, 1'b0, 1'b0, 1'b0,     c_D, 1'b0);
    end
  endfunction

  // Data row where both instances agree
  function automatic void add_d(input logic en, input logic [7:0] d,
                                input logic [7:0] oset, input logic k, input logic xmit,
                                input logic rdy);
    add(en, 1'b0, d, oset, k, xmit, 1'b0, rdy, oset, k);
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %02h expected %02h", nm, edge_n, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0b expected %0b", nm, edge_n, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, land 1 time unit after it
  task automatic step(input logic en, input logic er, input logic [7:0] d);
    TX_EN = en;
    TX_ER = er;
    TXD   = d;
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  function automatic logic exp_even(input int e);
    return (e % 2 == 0);
  endfunction

  task automatic exp_a(input logic [7:0] o, input logic k, input logic x);
    chk8("a_oset", a_oset, o);
    chk1("a_k", a_k, k);
    chk1("a_even", a_even, exp_even(edge_n));
    chk1("a_xmit", a_xmit, x);
  endtask

  task automatic exp_b(input logic [7:0] o, input logic k, input logic x);
    chk8("b_oset", b_oset, o);
    chk1("b_k", b_k, k);
    chk1("b_even", b_even, exp_even(edge_n));
    chk1("b_xmit", b_xmit, x);
  endtask

  // Idle until dut_a is ready, bounded; returns the edges spent waiting
  task automatic wait_ready(output int n);
    n = 0;
    while (a_rdy !== 1'b1 && n < 40) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk1("ready_wait", a_rdy, 1'b1);
  endtask

  task automatic exp_reset_state(input string tag);
    chk8({tag, "_a_oset"}, a_oset, c_I);
    chk1({tag, "_a_k"}, a_k, 1'b1);
    chk1({tag, "_a_even"}, a_even, 1'b1);
    chk1({tag, "_a_xmit"}, a_xmit, 1'b0);
    chk1({tag, "_a_drop"}, a_drop, 1'b0);
    chk1({tag, "_a_rdy"}, a_rdy, 1'b0);
    chk8({tag, "_b_oset"}, b_oset, c_I);
    chk1({tag, "_b_even"}, b_even, 1'b1);
    chk1({tag, "_b_xmit"}, b_xmit, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---- Vector table (edge numbers from reset release) ----
    add_idle(9, 1'b1);                                      // edges 1..9
    add_d(1'b1, 8'h55, c_S, 1'b1, 1'b0, 1'b1);              // 10 /S/
    add_d(1'b1, 8'hD5, 8'hD5, 1'b0, 1'b1, 1'b0);            // 11
    add_d(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);            // 12
    add_d(1'b1, 8'h02, 8'h02, 1'b0, 1'b1, 1'b0);            // 13
    add_d(1'b1, 8'h03, 8'h03, 1'b0, 1'b1, 1'b0);            // 14
    add_d(1'b0, 8'h00, c_T, 1'b1, 1'b1, 1'b0);              // 15 /T/ odd
    add_d(1'b0, 8'h00, c_R, 1'b1, 1'b0, 1'b0);              // 16 /R/ even
    add_d(1'b0, 8'h00, c_R, 1'b1, 1'b0, 1'b0);              // 17 pad /R/
    add_d(1'b0, 8'h00, c_I, 1'b1, 1'b0, 1'b0);              // 18 idle restarts even
    add_idle(1, 1'b0);                                      // 19
    add(1'b1, 1'b0, 8'h55, c_I, 1'b1, 1'b0, 1'b1, 1'b0, c_I, 1'b1); // 20 early -> drop
    add(1'b1, 1'b0, 8'h55, c_D, 1'b0, 1'b0, 1'b0, 1'b0, c_D, 1'b0); // 21
    add(1'b1, 1'b0, 8'h55, c_I, 1'b1, 1'b0, 1'b0, 1'b0, c_I, 1'b1); // 22
    add_idle(9, 1'b0);                                      // 23..31
    add_d(1'b1, 8'h55, c_S, 1'b1, 1'b0, 1'b1);              // 32 first ready after gap
    add_d(1'b1, 8'hD5, 8'hD5, 1'b0, 1'b1, 1'b0);            // 33
    add(1'b1, 1'b1, 8'h01, c_V, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0); // 34 error
    add_d(1'b1, 8'h02, 8'h02, 1'b0, 1'b1, 1'b0);            // 35
    add_d(1'b1, 8'h03, 8'h03, 1'b0, 1'b1, 1'b0);            // 36
    add_d(1'b0, 8'h00, c_T, 1'b1, 1'b1, 1'b0);              // 37
    add_d(1'b0, 8'h00, c_R, 1'b1, 1'b0, 1'b0);              // 38
    add_d(1'b0, 8'h00, c_R, 1'b1, 1'b0, 1'b0);              // 39
    add_d(1'b0, 8'h00, c_I, 1'b1, 1'b0, 1'b0);              // 40
    add_idle(13, 1'b0);                                     // 41..53
    add_d(1'b1, 8'h55, c_S, 1'b1, 1'b0, 1'b1);              // 54
    add_d(1'b1, 8'hAA, 8'hAA, 1'b0, 1'b1, 1'b0);            // 55
    add_d(1'b0, 8'h00, c_T, 1'b1, 1'b1, 1'b0);              // 56 /T/ even
    add_d(1'b0, 8'h00, c_R, 1'b1, 1'b0, 1'b0);              // 57 /R/ odd, no pad
    add_d(1'b0, 8'h00, c_I, 1'b1, 1'b0, 1'b0);              // 58
    add_idle(2, 1'b0);                                      // 59..60

    // ---- Reset state ----
    reset = 1'b1;
    TX_EN = 1'b0;
    TX_ER = 1'b0;
    TXD   = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    exp_reset_state("rst");
    @(negedge clock);
    reset = 1'b0;
    edge_n = 0;

    // ---- Table-driven section ----
    for (int i = 0; i < tbl.size(); i++) begin
      chk1("a_ready", a_rdy, tbl[i].rdy);
      chk1("b_ready", b_rdy, tbl[i].rdy);
      step(tbl[i].en, tbl[i].er, tbl[i].d);
      exp_a(tbl[i].oset, tbl[i].k, tbl[i].xmit);
      chk1("a_drop", a_drop, tbl[i].drop);
      exp_b(tbl[i].oset_b, tbl[i].k_b, tbl[i].xmit);
      chk1("b_drop", b_drop, tbl[i].drop);
    end

    // ---- Gap after an unpadded end: first ready before edge 72 ----
    wait_ready(n);
    chk1("b_ready_sync", b_rdy, 1'b1);
    chki("ipg_first_ready_edge", edge_n + 1, 72);

    // ---- Carrier extension (dut_a) vs. no extension (dut_b) ----
    step(1'b1, 1'b0, 8'h55); exp_a(c_S, 1'b1, 1'b0);   exp_b(c_S, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hD5); exp_a(8'hD5, 1'b0, 1'b1); exp_b(8'hD5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h0F); exp_a(c_T, 1'b1, 1'b1);   exp_b(c_T, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h0F); exp_a(c_R, 1'b1, 1'b1);   exp_b(c_R, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h0F); exp_a(c_R, 1'b1, 1'b1);   exp_b(c_I, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h0F); exp_a(c_R, 1'b1, 1'b1);   exp_b(c_D, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h1F); exp_a(c_V, 1'b1, 1'b1);   exp_b(c_I, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00); exp_a(c_R, 1'b1, 1'b0);   exp_b(c_D, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00); exp_a(c_I, 1'b1, 1'b0);   exp_b(c_I, 1'b1, 1'b0);

    // ---- Reset asserted mid-frame ----
    wait_ready(n);
    step(1'b1, 1'b0, 8'h55); exp_a(c_S, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h11); exp_a(8'h11, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h22); exp_a(8'h22, 1'b0, 1'b1);
    reset = 1'b1;
    TX_EN = 1'b0;
    #1;
    exp_reset_state("async");
    @(posedge clock);
    #1;
    exp_reset_state("held");
    @(negedge clock);
    reset = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 4; i++) begin
      chk1("post_rst_ready", a_rdy, (i % 2 == 1));
      step(1'b0, 1'b0, 8'h00);
      if (i % 2 == 0) exp_a(c_D, 1'b0, 1'b0);
      else            exp_a(c_I, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
